// File: rtl/shot_clock_ctrl.sv
// Shot clock controller: two-digit BCD countdown in whole seconds.
// Counting is driven by a prescaler that produces one tick every TICK_DIV
// clocks while running. When the count reaches 00 the buzzer pulses for
// BUZZ_CYCLES clocks. The controller then stays expired until reload or reset.
module shot_clock_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int PRESET_TENS = 2,
  parameter int PRESET_ONES = 4,
  parameter int BUZZ_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       reload,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       buzzer
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  // The counter holds the number of buzzer cycles still owed after the current one.
  localparam logic [BW-1:0] BUZZ_LOAD  = BW'(BUZZ_CYCLES - 1);
  localparam logic [3:0]    PRESET_T   = 4'(PRESET_TENS);
  localparam logic [3:0]    PRESET_O   = 4'(PRESET_ONES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
  logic          buzzer_q, buzzer_d;

  logic [3:0] dec_tens;
  logic [3:0] dec_ones;
  logic       digits_zero;
  logic       pause_eff;

  assign digits_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  // start outranks pause: when both arrive together, the pause is dropped.
  assign pause_eff   = pause && !start;

  // BCD decrement of the current digits. The result saturates at 00.
  always_comb begin
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end
  end

  // Next-state logic. Priority is reload, then start, then pause.
  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    presc_d    = presc_q;
    buzz_cnt_d = buzz_cnt_q;
    buzzer_d   = buzzer_q;

    if (reload) begin
      state_d    = S_IDLE;
      tens_d     = PRESET_T;
      ones_d     = PRESET_O;
      presc_d    = '0;
      buzz_cnt_d = '0;
      buzzer_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_PAUSE: begin
          if (start) begin
            if (digits_zero) begin
              state_d    = S_EXPIRED;
              buzzer_d   = 1'b1;
              buzz_cnt_d = BUZZ_LOAD;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (presc_q == PRESC_LAST) begin
            // Tick cycle: the decrement always lands, even if a pause arrives with it.
            presc_d = '0;
            tens_d  = dec_tens;
            ones_d  = dec_ones;
            if (dec_tens == 4'd0 && dec_ones == 4'd0) begin
              state_d    = S_EXPIRED;
              buzzer_d   = 1'b1;
              buzz_cnt_d = BUZZ_LOAD;
            end else if (pause_eff) begin
              state_d = S_PAUSE;
            end
          end else if (pause_eff) begin
            // Freeze the partial second so resume continues where it left off.
            state_d = S_PAUSE;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_EXPIRED: begin
          if (buzzer_q) begin
            if (buzz_cnt_q == '0) begin
              buzzer_d = 1'b0;
            end else begin
              buzz_cnt_d = buzz_cnt_q - BW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers. Reset overrides every command input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tens_q     <= PRESET_T;
      ones_q     <= PRESET_O;
      presc_q    <= '0;
      buzz_cnt_q <= '0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      presc_q    <= presc_d;
      buzz_cnt_q <= buzz_cnt_d;
      buzzer_q   <= buzzer_d;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign buzzer  = buzzer_q;
  assign running = (state_q == S_RUN);
  assign expired = (state_q == S_EXPIRED);

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Bench for shot_clock_ctrl, built with TICK_DIV=4, BUZZ_CYCLES=3 and preset 24.
// Checks come from three sources: a vector table, hand-written corner sequences,
// and random stimulus compared against a seconds-level reference model.
module tb_shot_clock_ctrl;

  localparam int TD = 4;
  localparam int BZ = 3;
  localparam int PRESET = 24;

  logic clk;
  logic reset, start, pause, reload;
  logic [3:0] tens, ones;
  logic running, expired, buzzer;

  int checks = 0;
  int failures = 0;

  shot_clock_ctrl #(
    .TICK_DIV(TD),
    .PRESET_TENS(2),
    .PRESET_ONES(4),
    .BUZZ_CYCLES(BZ)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .reload(reload),
    .tens(tens),
    .ones(ones),
    .running(running),
    .expired(expired),
    .buzzer(buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It tracks remaining whole seconds, the phase within the
  // current second, the controller mode, and buzzer cycles still owed.
  // Mode encoding: 0 idle, 1 run, 2 pause, 3 expired.
  int m_mode = 0;
  int m_secs = PRESET;
  int m_phase = 0;
  int m_buzz = 0;

  task automatic model_update(input logic r, input logic s, input logic p, input logic l);
    if (r || l) begin
      m_mode = 0; m_secs = PRESET; m_phase = 0; m_buzz = 0;
    end else begin
      case (m_mode)
        0, 2: if (s) begin
          if (m_secs == 0) begin m_mode = 3; m_buzz = BZ; end
          else m_mode = 1;
        end
        1: begin
          if (m_phase == TD - 1) begin
            m_phase = 0;
            if (m_secs > 0) m_secs = m_secs - 1;
            if (m_secs == 0) begin m_mode = 3; m_buzz = BZ; end
            else if (p && !s) m_mode = 2;
          end else if (p && !s) begin
            m_mode = 2;
          end else begin
            m_phase = m_phase + 1;
          end
        end
        3: if (m_buzz > 0) m_buzz = m_buzz - 1;
        default: m_mode = 0;
      endcase
    end
  endtask

  function automatic logic [10:0] pack(input int secs, input logic r, input logic e, input logic b);
    return {4'(secs / 10), 4'(secs % 10), r, e, b};
  endfunction

  function automatic logic [10:0] model_outs();
    return pack(m_secs, m_mode == 1, m_mode == 3, m_buzz > 0);
  endfunction

  function automatic logic [10:0] dut_outs();
    return {tens, ones, running, expired, buzzer};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got t=%0d o=%0d run=%b exp=%b buzz=%b, expected t=%0d o=%0d run=%b exp=%b buzz=%b",
               name, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Applies one set of commands for one clock edge and advances the model in step.
  task automatic cycle(input logic r, input logic s, input logic p, input logic l);
    reset = r; start = s; pause = p; reload = l;
    @(posedge clk);
    #1;
    model_update(r, s, p, l);
  endtask

  typedef struct {
    logic r, s, p, l;
    int   secs;
    logic run, ex, bz;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic p, input logic l,
                              input int secs, input logic run, input logic ex, input logic bz);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.l = l;
    v.secs = secs; v.run = run; v.ex = ex; v.bz = bz;
    return v;
  endfunction

  int prev;
  int cur;
  int ticks;
  int elapsed;
  int budget;
  int buzz_high;
  logic r_r, r_s, r_p, r_l;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; reload = 1'b0;

    // ---------------- table-driven vectors ----------------
    tbl.push_back(mk(1,0,0,0, 24,0,0,0));
    tbl.push_back(mk(0,0,0,0, 24,0,0,0));
    tbl.push_back(mk(0,0,0,0, 24,0,0,0));
    tbl.push_back(mk(0,1,0,0, 24,1,0,0));  // running rises, phase 0
    tbl.push_back(mk(0,0,0,0, 24,1,0,0));
    tbl.push_back(mk(0,0,0,0, 24,1,0,0));
    tbl.push_back(mk(0,0,0,0, 24,1,0,0));
    tbl.push_back(mk(0,0,0,0, 23,1,0,0));  // fourth edge after start
    tbl.push_back(mk(0,0,0,0, 23,1,0,0));
    tbl.push_back(mk(0,0,0,0, 23,1,0,0));
    tbl.push_back(mk(0,0,0,0, 23,1,0,0));
    tbl.push_back(mk(0,0,0,0, 22,1,0,0));
    tbl.push_back(mk(0,0,1,0, 22,0,0,0));  // pause at phase 0
    tbl.push_back(mk(0,0,0,0, 22,0,0,0));
    tbl.push_back(mk(0,1,0,0, 22,1,0,0));  // resume
    tbl.push_back(mk(0,0,0,0, 22,1,0,0));
    tbl.push_back(mk(0,0,0,0, 22,1,0,0));
    tbl.push_back(mk(0,0,0,0, 22,1,0,0));
    tbl.push_back(mk(0,0,0,0, 21,1,0,0));
    tbl.push_back(mk(0,1,1,1, 24,0,0,0));  // reload beats start and pause
    tbl.push_back(mk(0,1,0,0, 24,1,0,0));  // restart counts from phase 0
    tbl.push_back(mk(0,0,0,0, 24,1,0,0));
    tbl.push_back(mk(0,0,0,0, 24,1,0,0));
    tbl.push_back(mk(0,0,0,0, 24,1,0,0));
    tbl.push_back(mk(0,0,0,0, 23,1,0,0));

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].l);
      $display("vec %0d in r=%b s=%b p=%b l=%b -> t=%0d o=%0d run=%b exp=%b buzz=%b",
               i, tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].l, tens, ones, running, expired, buzzer);
      chk($sformatf("vec%0d", i), dut_outs(), pack(tbl[i].secs, tbl[i].run, tbl[i].ex, tbl[i].bz));
    end

    // ---------------- reset, then 10 idle cycles ----------------
    cycle(1,0,0,0);
    for (int i = 0; i < 10; i++) cycle(0,0,0,0);
    $display("idle10 -> t=%0d o=%0d run=%b exp=%b buzz=%b", tens, ones, running, expired, buzzer);
    chk("idle10", dut_outs(), pack(24,0,0,0));

    // ---------------- pause two cycles into a second ----------------
    cycle(0,1,0,0);                      // RUN, phase 0
    cycle(0,0,0,0);                      // phase 1
    cycle(0,0,0,0);                      // phase 2
    cycle(0,0,1,0);                      // pause holds phase 2
    for (int i = 0; i < 20; i++) begin
      cycle(0,0,0,0);
      chk("pause_hold", dut_outs(), pack(24,0,0,0));
    end
    cycle(0,1,0,0);
    chk("resume", dut_outs(), pack(24,1,0,0));
    cycle(0,0,0,0);
    chk("resume+1", dut_outs(), pack(24,1,0,0));
    cycle(0,0,0,0);
    $display("resume+2 -> t=%0d o=%0d run=%b", tens, ones, running);
    chk("resume+2", dut_outs(), pack(23,1,0,0));

    // ---------------- pause coinciding with a tick ----------------
    cycle(0,0,0,0); cycle(0,0,0,0); cycle(0,0,0,0);   // phase 3 (tick cycle)
    cycle(0,0,1,0);
    chk("pause_on_tick", dut_outs(), pack(22,0,0,0));

    // ---------------- run to zero, buzzer length, start ignored ----------------
    cycle(1,0,0,0);
    cycle(0,1,0,0);
    prev = PRESET; ticks = 0; elapsed = 0; budget = 400;
    while (!expired && budget > 0) begin
      cycle(0,0,0,0);
      elapsed++; budget--;
      cur = tens * 10 + ones;
      if (cur != prev) begin
        ticks++;
        $display("tick %0d -> t=%0d o=%0d run=%b exp=%b buzz=%b", ticks, tens, ones, running, expired, buzzer);
        if (cur == 0) chk("bcd_dec", dut_outs(), pack(prev - 1, 0, 1, 1));
        else chk("bcd_dec", dut_outs(), pack(prev - 1, 1, 0, 0));
        if (prev == 20) chk("20to19", dut_outs(), pack(19,1,0,0));
        prev = cur;
      end
    end
    chk_int("expire_reached", int'(expired), 1);
    chk_int("tick_count", ticks, PRESET);
    chk_int("expire_cycles", elapsed, PRESET * TD);
    buzz_high = buzzer ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0,0,0,0);
      if (buzzer) buzz_high++;
    end
    $display("buzzer high cycles=%0d", buzz_high);
    chk_int("buzz_len", buzz_high, BZ);
    cycle(0,1,0,0);
    chk("start_in_expired", dut_outs(), pack(0,0,1,0));
    cycle(0,0,1,0);
    chk("pause_in_expired", dut_outs(), pack(0,0,1,0));
    cycle(0,0,0,1);
    chk("reload_from_expired", dut_outs(), pack(24,0,0,0));

    // ---------------- reset mid-count at 07 ----------------
    cycle(0,1,0,0);
    budget = 400;
    while (!(tens == 4'd0 && ones == 4'd7) && budget > 0) begin
      cycle(0,0,0,0);
      budget--;
    end
    chk("reach07", dut_outs(), pack(7,1,0,0));
    cycle(1,0,0,0);
    $display("reset at 07 -> t=%0d o=%0d run=%b exp=%b buzz=%b", tens, ones, running, expired, buzzer);
    chk("reset_at07", dut_outs(), pack(24,0,0,0));

    // ---------------- reset while buzzer sounds ----------------
    cycle(0,1,0,0);
    budget = 400;
    while (!expired && budget > 0) begin
      cycle(0,0,0,0);
      budget--;
    end
    chk("expire_again", dut_outs(), pack(0,0,1,1));
    cycle(1,0,0,0);
    $display("reset in buzz -> t=%0d o=%0d run=%b exp=%b buzz=%b", tens, ones, running, expired, buzzer);
    chk("reset_in_buzz", dut_outs(), pack(24,0,0,0));

    // ---------------- randomized stimulus against the model ----------------
    cycle(1,0,0,0);
    chk("rand_reset", dut_outs(), model_outs());
    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(299) == 0);
      r_l = ($urandom_range(399) == 0);
      r_s = ($urandom_range(5) == 0);
      r_p = ($urandom_range(9) == 0);
      if (r_s && r_p && !r_l) r_p = 1'b0;
      cycle(r_r, r_s, r_p, r_l);
      chk($sformatf("rand%0d", i), dut_outs(), model_outs());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shot_clock_ctrl.md
SHOT_CLOCK_CTRL -- requirements
Module: shot_clock_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per one-second tick (minimum 2).
REQ-002 SHALL have parameter PRESET_TENS, default 2, meaning BCD tens digit loaded on reload (0-9).
REQ-003 SHALL have parameter PRESET_ONES, default 4, meaning BCD ones digit loaded on reload (0-9).
REQ-004 SHALL have parameter BUZZ_CYCLES, default 25000000, meaning clk cycles buzzer stays high after expiry (minimum 1).
REQ-005 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  single-cycle request to begin or resume counting.
REQ-008 SHALL have port pause  input  1  single-cycle request to freeze counting.
REQ-009 SHALL have port reload  input  1  single-cycle request to restore the preset and stop.
REQ-010 SHALL have port tens  output  4  BCD tens digit of remaining seconds, registered.
REQ-011 SHALL have port ones  output  4  BCD ones digit of remaining seconds, registered.
REQ-012 SHALL have port running  output  1  high exactly while state is RUN.
REQ-013 SHALL have port expired  output  1  high exactly while state is EXPIRED.
REQ-014 SHALL have port buzzer  output  1  registered buzzer drive.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, EXPIRED.
REQ-016 Command priority within one cycle SHALL be reload > start > pause; lower-priority commands in that cycle are ignored.
REQ-017 reload in any state SHALL: next state IDLE; tens/ones to preset; prescaler to 0; buzzer low; buzz counter to 0.
REQ-018 start in IDLE or PAUSE SHALL enter RUN next cycle if {tens,ones} != 00, else enter EXPIRED with buzzer behaviour per REQ-024.
REQ-019 start in RUN or EXPIRED SHALL have no effect.
REQ-020 pause in RUN SHALL enter PAUSE next cycle; prescaler and digits hold; pause in other states ignored.
REQ-021 Prescaler SHALL increment only in RUN; at TICK_DIV-1 it wraps to 0 and a tick is produced that cycle; it holds in PAUSE.
REQ-022 On tick, digits SHALL decrement as BCD: ones 0 -> ones 9 and tens-1; otherwise ones-1; update visible the cycle after the tick cycle.
REQ-023 Tick that brings digits to 00 SHALL move state to EXPIRED on the same edge as the digit update (running drops, expired rises together).
REQ-024 On entry to EXPIRED, buzzer SHALL go high on the same edge and stay high exactly BUZZ_CYCLES cycles, then low; digits hold 00.
REQ-025 EXPIRED SHALL be left only by reload or reset.
REQ-026 First tick after start from IDLE SHALL occur TICK_DIV cycles after running rises; after resume from PAUSE, the remaining prescaler count is honoured (no restart of the second).
REQ-027 A pause coinciding with a tick SHALL still apply that tick's decrement, then enter PAUSE (or EXPIRED if digits reach 00; EXPIRED wins).
REQ-028 Digits SHALL never leave BCD range or go below 00.

Reset
REQ-029 reset SHALL dominate all inputs, take effect on the next rising clk edge, and may be asserted mid-count.
REQ-030 After reset: state IDLE, tens=PRESET_TENS, ones=PRESET_ONES, prescaler 0, buzz counter 0, running=0, expired=0, buzzer=0.

Verification (TICK_DIV=4, BUZZ_CYCLES=3, preset 24)
REQ-031 Reset then idle 10 cycles -> tens=2, ones=4, running=0, expired=0, buzzer=0.
REQ-032 start pulse -> running=1 next cycle; digits 24->23 after 4 cycles, 23->22 after 4 more; 20->19 shows tens=1, ones=9.
REQ-033 Run, pause 2 cycles into a second, hold 20 cycles, start -> digits unchanged during pause; next decrement 2 cycles after resume.
REQ-034 Run to zero (24 ticks) -> digits 00, running=0, expired=1, buzzer high exactly 3 cycles; subsequent start ignored.
REQ-035 start, reload and pause asserted same cycle while RUN at 13 -> IDLE, digits 24, prescaler 0, running=0.
REQ-036 reset asserted while RUN at 07 with buzzer idle -> next cycle IDLE, digits 24, all flags 0; reset during EXPIRED buzzer -> buzzer low next cycle.
